// File: rtl/pipe_accum_tree_pkg.sv
// rtl/pipe_accum_tree_pkg.sv - width helpers and parameter legality checks for pipe_accum_tree
package pipe_accum_tree_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    // Accumulator width: sample width, plus tree growth, plus frame growth.
    function automatic int acc_width(input int w, input int nch, input int frame);
        return w + clog2(nch) + clog2(frame);
    endfunction

    function automatic bit nch_legal(input int nch);
        return (nch >= 2) && (nch <= 64) && ((nch & (nch - 1)) == 0);
    endfunction

    function automatic bit frame_legal(input int frame);
        return (frame >= 1) && (frame <= 1024);
    endfunction

    function automatic bit shift_legal(input int shift, input int accw);
        return (shift >= 0) && (shift < accw);
    endfunction

endpackage

// File: rtl/pipe_accum_tree_add_stage.sv
// rtl/pipe_accum_tree_add_stage.sv - one registered pairwise-add level of the adder tree
module add_stage #(
    parameter int N_IN = 2,
    parameter int IW   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           i_valid,
    input  logic [N_IN*IW-1:0]             i_data,
    output logic                           o_valid,
    output logic [(N_IN/2)*(IW+1)-1:0]     o_data
);

    localparam int N_OUT = N_IN / 2;
    localparam int OW    = IW + 1;

    logic [N_OUT*OW-1:0] w_pair_sum;
    logic [N_OUT*OW-1:0] r_data;
    logic                r_valid;

    // Adjacent lanes summed with one bit of growth so nothing is lost.
    always_comb begin
        w_pair_sum = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_pair_sum[k*OW +: OW] = OW'(i_data[(2*k)*IW +: IW]) + OW'(i_data[(2*k+1)*IW +: IW]);
        end
    end

    // Level register; data only moves with a valid sample, the valid bit is flushed by clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (clear) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_pair_sum;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_accum_tree.sv
// rtl/pipe_accum_tree.sv - pipelined channel adder tree feeding a frame accumulator; PIPE_ACCUM_TREE_ROUND_EN selects round-half-up scaling
module pipe_accum_tree
    import pipe_accum_tree_pkg::*;
#(
    parameter int NCH   = 8,
    parameter int W     = 8,
    parameter int FRAME = 32,
    parameter int SHIFT = 8,
    parameter int OUT_W = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clear,
    input  logic                                  in_valid,
    input  logic [NCH*W-1:0]                      in_data,
    output logic                                  out_valid,
    output logic [OUT_W-1:0]                      out_sum,
    output logic                                  out_sat,
    output logic [acc_width(W, NCH, FRAME)-1:0]   acc_sum
);

    localparam int L     = clog2(NCH);
    localparam int ACC_W = acc_width(W, NCH, FRAME);
    localparam int CNT_W = (clog2(FRAME) > 0) ? clog2(FRAME) : 1;
    localparam int SC_W  = ACC_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

`ifdef PIPE_ACCUM_TREE_ROUND_EN
    localparam logic [SC_W-1:0] RND = (SHIFT == 0) ? '0 : (SC_W'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0));
`else
    localparam logic [SC_W-1:0] RND = '0;
`endif

    if (!nch_legal(NCH)) begin : g_bad_nch
        $error("pipe_accum_tree: NCH must be a power of two in 2..64");
    end
    if (!frame_legal(FRAME)) begin : g_bad_frame
        $error("pipe_accum_tree: FRAME must be in 1..1024");
    end
    if (!shift_legal(SHIFT, ACC_W)) begin : g_bad_shift
        $error("pipe_accum_tree: SHIFT must be in 0..ACC_W-1");
    end

    logic                r_in_valid;
    logic [NCH*W-1:0]    r_in_data;
    logic                w_tree_valid;
    logic [W+L-1:0]      w_tree_data;
    logic [ACC_W-1:0]    w_sum;
    logic [SC_W-1:0]     w_round;
    logic [SC_W-1:0]     w_scaled;
    logic                w_sat;
    logic [OUT_W-1:0]    w_out_sum;

    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_out_valid;
    logic [OUT_W-1:0]    r_out_sum;
    logic                r_out_sat;
    logic [ACC_W-1:0]    r_acc_sum;

    // Input capture stage; a sample arriving with clear is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_valid <= 1'b0;
            r_in_data  <= '0;
        end else if (clear) begin
            r_in_valid <= 1'b0;
        end else begin
            r_in_valid <= in_valid;
            if (in_valid) begin
                r_in_data <= in_data;
            end
        end
    end

    for (genvar l = 0; l < L; l++) begin : g_lvl
        localparam int N_IN = NCH >> l;
        localparam int IW   = W + l;
        logic                       w_valid;
        logic [(N_IN/2)*(IW+1)-1:0] w_data;
        if (l == 0) begin : g_first
            add_stage #(.N_IN(N_IN), .IW(IW)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .clear   (clear),
                .i_valid (r_in_valid),
                .i_data  (r_in_data),
                .o_valid (w_valid),
                .o_data  (w_data)
            );
        end else begin : g_next
            add_stage #(.N_IN(N_IN), .IW(IW)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .clear   (clear),
                .i_valid (g_lvl[l-1].w_valid),
                .i_data  (g_lvl[l-1].w_data),
                .o_valid (w_valid),
                .o_data  (w_data)
            );
        end
    end

    assign w_tree_valid = g_lvl[L-1].w_valid;
    assign w_tree_data  = g_lvl[L-1].w_data;

    assign w_sum    = r_acc + ACC_W'(w_tree_data);
    assign w_round  = {1'b0, w_sum} + RND;
    assign w_scaled = w_round >> SHIFT;

    if (OUT_W < SC_W) begin : g_clip
        assign w_sat     = |w_scaled[SC_W-1:OUT_W];
        assign w_out_sum = w_sat ? '1 : w_scaled[OUT_W-1:0];
    end else begin : g_noclip
        assign w_sat     = 1'b0;
        assign w_out_sum = OUT_W'(w_scaled);
    end

    // Frame accumulator: adds each tree result, emits and restarts on the FRAME-th sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_sat   <= 1'b0;
            r_acc_sum   <= '0;
        end else if (clear) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_tree_valid) begin
                if (r_cnt == CNT_LAST) begin
                    r_acc_sum   <= w_sum;
                    r_out_sum   <= w_out_sum;
                    r_out_sat   <= w_sat;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_sat   = r_out_sat;
    assign acc_sum   = r_acc_sum;

endmodule

// File: doc/pipe_accum_tree.md
PIPE_ACCUM_TREE -- requirements
Module: pipe_accum_tree

Interface
REQ-001 SHALL have parameter NCH, default 8, meaning input channel count; legal values are powers of two, 2..64.
REQ-002 SHALL have parameter W, default 8, meaning unsigned sample width per channel.
REQ-003 SHALL have parameter FRAME, default 32, meaning number of valid samples per accumulation frame; legal range is 1..1024.
REQ-004 SHALL have parameter SHIFT, default 8, meaning right-shift applied to the frame sum; legal range is 0..ACC_W-1.
REQ-005 SHALL have parameter OUT_W, default 8, meaning output result width.
REQ-006 SHALL have port clk, input, 1 bit: clock; reset rst, synchronous, active-high.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port clear, input, 1 bit: synchronous flush of pipeline and frame.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data is a sample this cycle.
REQ-010 SHALL have port in_data, input, NCH*W bits: channel k occupies bits [k*W +: W].
REQ-011 SHALL have port out_valid, output, 1 bit: one-cycle pulse carrying the frame result.
REQ-012 SHALL have port out_sum, output, OUT_W bits: scaled, saturated frame result.
REQ-013 SHALL have port out_sat, output, 1 bit: out_sum was clipped; qualified by out_valid.
REQ-014 SHALL have port acc_sum, output, ACC_W bits: raw frame sum, qualified by out_valid.

Function
REQ-015 SHALL define L = log2(NCH) and ACC_W = W + log2(NCH) + clog2(FRAME), so that no internal sum overflows.
REQ-016 SHALL implement an L-level binary adder tree with one register stage per level; the valid bit travels alongside the data.
REQ-017 SHALL add the tree output to the accumulator on the clock edge at which the tree valid reaches the accumulator stage.
REQ-018 SHALL count accumulated samples from 0 to FRAME-1; on the edge that adds the FRAME-th sample it SHALL:
- register acc_sum = acc + tree_out;
- assert out_valid for exactly one cycle;
- zero the accumulator and the count.
REQ-019 SHALL make out_valid visible L+1 edges after the edge sampling the last in_valid of the frame.
REQ-020 SHALL tolerate in_valid gaps of any length; idle cycles SHALL NOT alter acc or count; there is no backpressure.
REQ-021 SHALL accept a new frame's first sample in the cycle immediately after the previous frame's last sample, with no bubble.
REQ-022 SHALL compute out_sum as scaled = rounded/truncated acc_sum >> SHIFT (see Configuration); if scaled > 2^OUT_W-1, out_sum SHALL be all-ones and out_sat = 1, otherwise out_sat = 0.
REQ-023 SHALL hold out_sum, out_sat and acc_sum between pulses.
REQ-024 SHALL, when clear is asserted, zero all pipeline valids, the accumulator and the count on that edge; in_valid in the same cycle is dropped; output registers are held.
REQ-025 SHALL give clear priority over frame completion when both coincide: no out_valid is produced.

Reset
REQ-026 SHALL, on rst, set out_valid = 0, out_sum = 0, out_sat = 0, acc_sum = 0, accumulator = 0, count = 0 and all pipeline valids = 0.
REQ-027 SHALL give rst priority over clear and in_valid; rst mid-frame discards the partial frame, and the next frame starts at count 0.

Configuration
REQ-028 SHALL, with macro PIPE_ACCUM_TREE_ROUND_EN defined, compute scaled = (acc_sum + 2^(SHIFT-1)) >> SHIFT, with no rounding term when SHIFT = 0; the adder SHALL be ACC_W+1 bits.
REQ-029 SHALL, without PIPE_ACCUM_TREE_ROUND_EN, compute scaled = acc_sum >> SHIFT (truncation).

Structure
REQ-030 SHALL place the clog2 function, the ACC_W derivation function and the legal-parameter checks in shared package pipe_accum_tree_pkg.
REQ-031 SHALL implement one tree level as sub-module add_stage, parameterised by input count and width, performing registered pairwise adds plus valid; it is instantiated L times.

Verification (NCH=8, W=8, FRAME=32, SHIFT=8, OUT_W=8 unless noted)
REQ-032 SHALL cover: all channels 255 for 32 consecutive valids -> acc_sum=65280, out_sum=255, out_sat=0, out_valid pulse at edge 32+L (L=3).
REQ-033 SHALL cover: ch0=128, others 0, one frame -> acc_sum=4096, out_sum=16; then ch0=4 only -> acc_sum=128, out_sum=1 with ROUND_EN, 0 without.
REQ-034 SHALL cover: all channels 1 with in_valid toggling every cycle -> out_valid after the 32nd valid only, out_sum=1, no pulse earlier.
REQ-035 SHALL cover: SHIFT=4, all channels 255 -> scaled=4080, out_sum=255, out_sat=1.
REQ-036 SHALL cover: rst after 10 valids, then 32 valids of all 2 -> acc_sum=512, out_sum=2; clear coincident with the 32nd valid -> no out_valid.
REQ-037 SHALL cover: back-to-back frames of 64 valids (values 1 then 3) -> two pulses 32 cycles apart, out_sum=1 then 3.
